// File: rtl/switch_debounce_array.sv
// -----------------------------------------------------------------------------
// switch_debounce_array
//
// Multi-channel push-button conditioner. Each channel has a two-flop
// synchroniser, a debounce counter and a registered debounced level. It also
// produces one-cycle press/release pulses and an optional hold-to-repeat
// pulse train. Channels share no state.
//
// Ports:
//   i_Clk        system clock
//   i_Rst_n      asynchronous active-low reset
//   i_Switches   raw asynchronous switch inputs, one bit per channel
//   i_Repeat_En  per-channel hold-to-repeat enable (synchronous to i_Clk)
//   o_Switches   debounced level, 1 = pressed
//   o_Press      one-cycle pulse on the edge o_Switches rises
//   o_Release    one-cycle pulse on the edge o_Switches falls
//   o_Repeat     one-cycle auto-repeat pulse while a channel is held
// -----------------------------------------------------------------------------
module switch_debounce_array #(
   parameter int NUM_CH         = 4,
   parameter int DEBOUNCE_LIMIT = 250000,
   parameter int REPEAT_DELAY   = 12500000,
   parameter int REPEAT_PERIOD  = 2500000,
   parameter int INVERT         = 0
) (
   input  logic              i_Clk,
   input  logic              i_Rst_n,
   input  logic [NUM_CH-1:0] i_Switches,
   input  logic [NUM_CH-1:0] i_Repeat_En,
   output logic [NUM_CH-1:0] o_Switches,
   output logic [NUM_CH-1:0] o_Press,
   output logic [NUM_CH-1:0] o_Release,
   output logic [NUM_CH-1:0] o_Repeat
);

   localparam int DB_W    = $clog2(DEBOUNCE_LIMIT + 1);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HOLD_W  = $clog2(RPT_MAX + 1);

   localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_LIMIT - 1);
   localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
   localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);
   localparam logic [NUM_CH-1:0] INV_MASK    = (INVERT != 0) ? '1 : '0;

   // DELAY: waiting for the first repeat after the press; PERIOD: steady train.
   typedef enum logic {
      PH_DELAY  = 1'b0,
      PH_PERIOD = 1'b1
   } phase_e;

   logic [NUM_CH-1:0] sync1_q,   sync1_d;
   logic [NUM_CH-1:0] sync2_q,   sync2_d;
   logic [NUM_CH-1:0] state_q,   state_d;
   logic [NUM_CH-1:0] press_q,   press_d;
   logic [NUM_CH-1:0] release_q, release_d;
   logic [NUM_CH-1:0] repeat_q,  repeat_d;
   logic [DB_W-1:0]   cnt_q   [NUM_CH];
   logic [DB_W-1:0]   cnt_d   [NUM_CH];
   logic [HOLD_W-1:0] hcnt_q  [NUM_CH];
   logic [HOLD_W-1:0] hcnt_d  [NUM_CH];
   phase_e            phase_q [NUM_CH];
   phase_e            phase_d [NUM_CH];

   always_comb begin
      logic [HOLD_W-1:0] tgt_last;
      tgt_last = DELAY_LAST;
      sync1_d  = i_Switches ^ INV_MASK;
      sync2_d  = sync1_q;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         state_d[ch]   = state_q[ch];
         press_d[ch]   = 1'b0;
         release_d[ch] = 1'b0;
         repeat_d[ch]  = 1'b0;
         // A single agreeing sample throws away the whole accumulated count.
         cnt_d[ch]     = '0;
         hcnt_d[ch]    = '0;
         phase_d[ch]   = PH_DELAY;

         if (sync2_q[ch] != state_q[ch]) begin
            if (cnt_q[ch] == DB_LAST) begin
               state_d[ch]   = sync2_q[ch];
               press_d[ch]   = sync2_q[ch];
               release_d[ch] = ~sync2_q[ch];
            end else begin
               cnt_d[ch] = cnt_q[ch] + DB_W'(1);
            end
         end

         // Press and release edges restart the hold timer and win over repeat.
         if (!press_d[ch] && !release_d[ch] && state_q[ch] && i_Repeat_En[ch]) begin
            tgt_last = (phase_q[ch] == PH_PERIOD) ? PERIOD_LAST : DELAY_LAST;
            if (hcnt_q[ch] == tgt_last) begin
               repeat_d[ch] = 1'b1;
               phase_d[ch]  = PH_PERIOD;
            end else begin
               hcnt_d[ch]  = hcnt_q[ch] + HOLD_W'(1);
               phase_d[ch] = phase_q[ch];
            end
         end
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         state_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         repeat_q  <= '0;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            cnt_q[ch]   <= '0;
            hcnt_q[ch]  <= '0;
            phase_q[ch] <= PH_DELAY;
         end
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         state_q   <= state_d;
         press_q   <= press_d;
         release_q <= release_d;
         repeat_q  <= repeat_d;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            cnt_q[ch]   <= cnt_d[ch];
            hcnt_q[ch]  <= hcnt_d[ch];
            phase_q[ch] <= phase_d[ch];
         end
      end
   end

   assign o_Switches = state_q;
   assign o_Press    = press_q;
   assign o_Release  = release_q;
   assign o_Repeat   = repeat_q;

endmodule
